// File: rtl/memory_stage.sv
// MEM pipeline stage: 4Kx16 data memory, 12-bit stack pointer, and MEM/WB registers.
// Two-word ops (CALL push / RET pop) take two cycles. stall_out holds EX/MEM during the first cycle.
module memory_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] alu_result,
  input  logic [15:0] read_data1,
  input  logic [15:0] read_data2,
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus_one,
  input  logic        pc_choose_memory,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_push,
  input  logic        mem_pop,
  input  logic [1:0]  memory_address_select,
  input  logic [1:0]  memory_write_src_select,
  input  logic        reg_write,
  input  logic        outport_enable,
  input  logic [1:0]  wb_sel,
  input  logic [2:0]  reg_write_address,
  input  logic [15:0] LDM_value,
  output logic        stall_out,
  output logic [15:0] mem_data_out,
  output logic [15:0] result_out,
  output logic [15:0] read_data1_out,
  output logic [15:0] LDM_value_out,
  output logic        reg_write_out,
  output logic        outport_enable_out,
  output logic [1:0]  wb_sel_out,
  output logic [2:0]  reg_write_address_out,
  output logic [31:0] pc_from_memory,
  output logic        pc_load,
  output logic [11:0] sp_out
);
  typedef enum logic {IDLE, WORD2} state_e;

  state_e      state_q, state_d;
  logic [11:0] sp_q, sp_d;
  logic [15:0] lo_q, lo_d;
  logic        push_op_q, push_op_d;
  logic [31:0] pc_mem_q, pc_mem_d;
  logic        pc_load_q, pc_load_d;
  logic [15:0] mdo_q, mdo_d, res_q, res_d, rd1_q, rd1_d, ldm_q, ldm_d;
  logic        rw_q, rw_d, oe_q, oe_d;
  logic [1:0]  wb_q, wb_d;
  logic [2:0]  ra_q, ra_d;

  logic [15:0] mem [0:4095];
  logic        we, rd_en, first;
  logic [11:0] waddr, raddr, sel_addr, sp_inc;
  logic [15:0] wdata, rdata;
  logic [31:0] src32;
  logic        do_push, do_pop, do_wr, do_rd, two_word;

  // Upper address bits are ignored: the memory is word-addressed by the low 12 bits only.
  logic unused_addr_bits;
  assign unused_addr_bits = ^alu_result[15:12];

  assign do_push  = mem_push;
  assign do_pop   = !mem_push && mem_pop;
  assign do_wr    = !mem_push && !mem_pop && mem_write;
  assign do_rd    = !mem_push && !mem_pop && !mem_write && mem_read;
  assign two_word = (do_push && (memory_write_src_select == 2'b01 ||
                                 memory_write_src_select == 2'b10)) ||
                    (do_pop && pc_choose_memory);
  assign src32    = (memory_write_src_select == 2'b10) ? pc : pc_plus_one;
  assign sp_inc   = sp_q + 12'd1;

  always_comb begin
    case (memory_address_select)
      2'b01:   sel_addr = sp_q;
      2'b10:   sel_addr = sp_inc;
      default: sel_addr = alu_result[11:0];
    endcase
  end

  // Pops (both words) always read at SP+1. Every other read uses the selected address.
  assign raddr = (state_q == WORD2 || do_pop) ? sp_inc : sel_addr;
  assign rdata = mem[raddr];

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    lo_d      = lo_q;
    push_op_d = push_op_q;
    pc_mem_d  = pc_mem_q;
    pc_load_d = 1'b0;
    we        = 1'b0;
    waddr     = sp_q;
    wdata     = read_data2;
    rd_en     = 1'b0;
    first     = 1'b0;
    stall_out = 1'b0;
    if (state_q == WORD2) begin
      state_d = IDLE;
      if (push_op_q) begin
        we    = 1'b1;
        wdata = src32[15:0];
        sp_d  = sp_q - 12'd1;
      end else begin
        rd_en     = 1'b1;
        sp_d      = sp_inc;
        pc_mem_d  = {rdata, lo_q};
        pc_load_d = 1'b1;
      end
    end else begin
      if (do_push) begin
        we    = 1'b1;
        wdata = two_word ? src32[31:16] : read_data2;
        sp_d  = sp_q - 12'd1;
      end else if (do_pop) begin
        rd_en = 1'b1;
        sp_d  = sp_inc;
        lo_d  = rdata;
      end else if (do_wr) begin
        we    = 1'b1;
        waddr = sel_addr;
      end else if (do_rd) begin
        rd_en = 1'b1;
      end
      if (two_word) begin
        stall_out = 1'b1;
        first     = 1'b1;
        push_op_d = do_push;
        state_d   = WORD2;
      end
    end
    // Reset aborts any access in flight; memory contents survive reset.
    if (reset) begin
      we        = 1'b0;
      stall_out = 1'b0;
    end
  end

  always_comb begin
    mdo_d = rd_en ? rdata : 16'h0000;
    res_d = alu_result;
    rd1_d = read_data1;
    ldm_d = LDM_value;
    rw_d  = first ? 1'b0 : reg_write;
    oe_d  = first ? 1'b0 : outport_enable;
    wb_d  = wb_sel;
    ra_d  = reg_write_address;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sp_q      <= 12'hFFF;
      lo_q      <= '0;
      push_op_q <= 1'b0;
      pc_mem_q  <= '0;
      pc_load_q <= 1'b0;
      mdo_q     <= '0;
      res_q     <= '0;
      rd1_q     <= '0;
      ldm_q     <= '0;
      rw_q      <= 1'b0;
      oe_q      <= 1'b0;
      wb_q      <= '0;
      ra_q      <= '0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      lo_q      <= lo_d;
      push_op_q <= push_op_d;
      pc_mem_q  <= pc_mem_d;
      pc_load_q <= pc_load_d;
      mdo_q     <= mdo_d;
      res_q     <= res_d;
      rd1_q     <= rd1_d;
      ldm_q     <= ldm_d;
      rw_q      <= rw_d;
      oe_q      <= oe_d;
      wb_q      <= wb_d;
      ra_q      <= ra_d;
    end
  end

  assign mem_data_out          = mdo_q;
  assign result_out            = res_q;
  assign read_data1_out        = rd1_q;
  assign LDM_value_out         = ldm_q;
  assign reg_write_out         = rw_q;
  assign outport_enable_out    = oe_q;
  assign wb_sel_out            = wb_q;
  assign reg_write_address_out = ra_q;
  assign pc_from_memory        = pc_mem_q;
  assign pc_load               = pc_load_q;
  assign sp_out                = sp_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: an operation-level model (shadow memory + SP) predicts every
// cycle's outputs. A single compare process checks stall_out mid-cycle and the registered outputs after each edge.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] alu_result = '0, read_data1 = '0, read_data2 = '0, LDM_value = '0;
  logic [31:0] pc = '0, pc_plus_one = '0;
  logic        pc_choose_memory = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic        mem_push = 1'b0, mem_pop = 1'b0, reg_write = 1'b0, outport_enable = 1'b0;
  logic [1:0]  memory_address_select = '0, memory_write_src_select = '0, wb_sel = '0;
  logic [2:0]  reg_write_address = '0;
  logic        stall_out, reg_write_out, outport_enable_out, pc_load;
  logic [15:0] mem_data_out, result_out, read_data1_out, LDM_value_out;
  logic [1:0]  wb_sel_out;
  logic [2:0]  reg_write_address_out;
  logic [31:0] pc_from_memory;
  logic [11:0] sp_out;

  memory_stage dut (
    .clk(clk), .reset(reset), .alu_result(alu_result), .read_data1(read_data1),
    .read_data2(read_data2), .pc(pc), .pc_plus_one(pc_plus_one),
    .pc_choose_memory(pc_choose_memory), .mem_read(mem_read), .mem_write(mem_write),
    .mem_push(mem_push), .mem_pop(mem_pop), .memory_address_select(memory_address_select),
    .memory_write_src_select(memory_write_src_select), .reg_write(reg_write),
    .outport_enable(outport_enable), .wb_sel(wb_sel), .reg_write_address(reg_write_address),
    .LDM_value(LDM_value), .stall_out(stall_out), .mem_data_out(mem_data_out),
    .result_out(result_out), .read_data1_out(read_data1_out), .LDM_value_out(LDM_value_out),
    .reg_write_out(reg_write_out), .outport_enable_out(outport_enable_out),
    .wb_sel_out(wb_sel_out), .reg_write_address_out(reg_write_address_out),
    .pc_from_memory(pc_from_memory), .pc_load(pc_load), .sp_out(sp_out)
  );

  always #5 clk = ~clk;

  // Model state
  logic [15:0] m [0:4095];
  logic [11:0] msp = 12'hFFF;
  logic [31:0] mpc = '0;

  // Expected values for the edge that ends the current cycle
  logic        chk = 1'b0;
  logic        e_stall, e_rw, e_oe, e_pcl;
  logic [15:0] e_mdo, e_res, e_rd1, e_ldm;
  logic [1:0]  e_wb;
  logic [2:0]  e_ra;
  logic [31:0] e_pc;
  logic [11:0] e_sp;
  int errs = 0, checks = 0;

  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk); #3;
      if (chk) begin
        ck("stall_out", {31'b0, stall_out}, {31'b0, e_stall});
        @(posedge clk); #1;
        ck("mem_data_out", {16'b0, mem_data_out}, {16'b0, e_mdo});
        ck("result_out", {16'b0, result_out}, {16'b0, e_res});
        ck("read_data1_out", {16'b0, read_data1_out}, {16'b0, e_rd1});
        ck("LDM_value_out", {16'b0, LDM_value_out}, {16'b0, e_ldm});
        ck("reg_write_out", {31'b0, reg_write_out}, {31'b0, e_rw});
        ck("outport_enable_out", {31'b0, outport_enable_out}, {31'b0, e_oe});
        ck("wb_sel_out", {30'b0, wb_sel_out}, {30'b0, e_wb});
        ck("reg_write_address_out", {29'b0, reg_write_address_out}, {29'b0, e_ra});
        ck("pc_load", {31'b0, pc_load}, {31'b0, e_pcl});
        ck("pc_from_memory", pc_from_memory, e_pc);
        ck("sp_out", {20'b0, sp_out}, {20'b0, e_sp});
      end
    end
  end

  task automatic go(input logic [15:0] mdo, input logic stl, input logic first, input logic pcl);
    e_mdo = mdo; e_stall = stl; e_pcl = pcl; e_pc = mpc; e_sp = msp;
    e_res = alu_result; e_rd1 = read_data1; e_ldm = LDM_value;
    e_rw = first ? 1'b0 : reg_write; e_oe = first ? 1'b0 : outport_enable;
    e_wb = wb_sel; e_ra = reg_write_address; chk = 1'b1;
  endtask

  task automatic go_reset();
    e_mdo = '0; e_stall = 1'b0; e_pcl = 1'b0; e_pc = '0; e_sp = 12'hFFF;
    e_res = '0; e_rd1 = '0; e_ldm = '0; e_rw = 1'b0; e_oe = 1'b0;
    e_wb = '0; e_ra = '0; chk = 1'b1;
  endtask

  task automatic begin_cyc();
    @(negedge clk);
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_push = 1'b0; mem_pop = 1'b0;
    pc_choose_memory = 1'b0; memory_address_select = '0; memory_write_src_select = '0;
    alu_result = 16'($urandom); read_data1 = 16'($urandom); read_data2 = 16'($urandom);
    LDM_value = 16'($urandom); pc = $urandom; pc_plus_one = $urandom;
    reg_write = 1'($urandom); outport_enable = 1'($urandom);
    wb_sel = 2'($urandom); reg_write_address = 3'($urandom);
  endtask

  task automatic lit(input string nm, input logic [31:0] act_sel, input logic [31:0] exp);
    ck(nm, act_sel, exp);
  endtask

  task automatic after_edge();
    @(posedge clk); #2;
  endtask

  task automatic std_op(input logic [15:0] a, input logic [15:0] d);
    begin_cyc(); mem_write = 1'b1; alu_result = a; read_data2 = d;
    m[a[11:0]] = d; go(16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ldd_op(input logic [15:0] a, input logic [1:0] asel);
    logic [11:0] ad;
    begin_cyc(); mem_read = 1'b1; alu_result = a; memory_address_select = asel;
    case (asel)
      2'b01:   ad = msp;
      2'b10:   ad = msp + 12'd1;
      default: ad = a[11:0];
    endcase
    go(m[ad], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push16(input logic [15:0] d, input logic also_pop);
    begin_cyc(); mem_push = 1'b1; mem_pop = also_pop; read_data2 = d;
    m[msp] = d; msp = msp - 12'd1; go(16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop16();
    begin_cyc(); mem_pop = 1'b1;
    msp = msp + 12'd1; go(m[msp], 1'b0, 1'b0, 1'b0);
  endtask

  // pop + write + read in one cycle: only the pop may take effect
  task automatic pop_vs_write(input logic [15:0] a, input logic [15:0] d);
    begin_cyc(); mem_pop = 1'b1; mem_write = 1'b1; mem_read = 1'b1; alu_result = a; read_data2 = d;
    msp = msp + 12'd1; go(m[msp], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_vs_read(input logic [15:0] a, input logic [15:0] d);
    begin_cyc(); mem_write = 1'b1; mem_read = 1'b1; alu_result = a; read_data2 = d;
    m[a[11:0]] = d; go(16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push32(input logic [31:0] v, input logic [1:0] sel, input logic abort);
    begin_cyc(); mem_push = 1'b1; memory_write_src_select = sel;
    if (sel == 2'b10) pc = v; else pc_plus_one = v;
    m[msp] = v[31:16]; msp = msp - 12'd1; go(16'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    if (abort) begin
      reset = 1'b1; msp = 12'hFFF; mpc = '0; go_reset();
    end else begin
      m[msp] = v[15:0]; msp = msp - 12'd1; go(16'h0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pop32();
    logic [15:0] lo, hi;
    begin_cyc(); mem_pop = 1'b1; pc_choose_memory = 1'b1;
    msp = msp + 12'd1; lo = m[msp]; go(lo, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    msp = msp + 12'd1; hi = m[msp]; mpc = {hi, lo}; go(hi, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // reset state
    @(negedge clk); go_reset();
    @(negedge clk); go_reset();
    after_edge();
    lit("reset sp_out", {20'b0, sp_out}, 32'h0000_0FFF);

    // STD then LDD
    std_op(16'h0010, 16'hBEEF);
    ldd_op(16'h0010, 2'b00);
    after_edge();
    lit("ldd mem_data_out", {16'b0, mem_data_out}, 32'h0000_BEEF);

    // 16-bit push then pop
    push16(16'h1234, 1'b0);
    after_edge();
    lit("push16 sp_out", {20'b0, sp_out}, 32'h0000_0FFE);
    pop16();
    after_edge();
    lit("pop16 data", {16'b0, mem_data_out}, 32'h0000_1234);

    // CALL push and RET pop
    push32(32'h0001_0020, 2'b01, 1'b0);
    after_edge();
    lit("call sp_out", {20'b0, sp_out}, 32'h0000_0FFD);
    ldd_op(16'h0FFF, 2'b00);
    ldd_op(16'h0FFE, 2'b00);
    after_edge();
    lit("call low word", {16'b0, mem_data_out}, 32'h0000_0020);
    pop32();
    after_edge();
    lit("ret pc_from_memory", pc_from_memory, 32'h0001_0020);
    lit("ret pc_load", {31'b0, pc_load}, 32'h1);
    push32(32'hCAFE_F00D, 2'b10, 1'b0);
    pop32();

    // collisions and address selects
    std_op(16'h0100, 16'h1111);
    push16(16'h5555, 1'b1);
    ldd_op(16'h0000, 2'b10);
    ldd_op(16'h0000, 2'b01);
    ldd_op(16'h0010, 2'b11);
    pop_vs_write(16'h0100, 16'h2222);
    ldd_op(16'h0100, 2'b00);
    after_edge();
    lit("losing write ignored", {16'b0, mem_data_out}, 32'h0000_1111);
    write_vs_read(16'h0200, 16'h3333);
    ldd_op(16'h0200, 2'b00);

    // reset during the second word of a CALL push
    push32(32'hAAAA_BBBB, 2'b01, 1'b1);
    ldd_op(16'h0FFE, 2'b00);
    after_edge();
    lit("abort keeps mem[FFE]", {16'b0, mem_data_out}, 32'h0000_F00D);
    lit("abort sp_out", {20'b0, sp_out}, 32'h0000_0FFF);
    ldd_op(16'h0FFF, 2'b00);

    // SP wrap in both directions
    for (int i = 0; msp != 12'h000; i++) push16(16'(i), 1'b0);
    push16(16'hABCD, 1'b0);
    after_edge();
    lit("wrap push sp_out", {20'b0, sp_out}, 32'h0000_0FFF);
    pop16();
    after_edge();
    lit("wrap pop data", {16'b0, mem_data_out}, 32'h0000_ABCD);
    lit("wrap pop sp_out", {20'b0, sp_out}, 32'h0);
    pop16();

    @(posedge clk); #3;
    chk = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
